sum_accumulator: RTL
====================

Name: sum_accumulator

Overview:
- Downstream consumer of the registered 4-bit adder stage.
- Each cycle it may accept one {carry, sum} result, a 5-bit value in the range 0..31.
- It accumulates NUM_SAMPLES accepted results into an ACC_W-bit total.
- It then presents the total with a valid/ready handshake and holds it until the next stage takes it.

Parameters:
- NUM_SAMPLES, 16, number of accepted input results per batch; legal range 2..255.
- ACC_W, 8, accumulator and output width; minimum 5.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  sum_in/carry_in hold a valid adder result this cycle.
- sum_in  input  4  adder sum (from sum_out of the adder stage).
- carry_in  input  1  adder carry (from carry_out of the adder stage).
- in_ready  output  1  block accepts input this cycle.
- clear  input  1  synchronous batch abort/restart.
- out_valid  output  1  acc_out holds a completed batch total.
- out_ready  input  1  downstream consumes the total.
- acc_out  output  ACC_W  batch total.
- overflow  output  1  sticky: the batch total exceeded ACC_W bits.
- count  output  CW  accepted samples in the current batch; CW = $clog2(NUM_SAMPLES+1).

Behaviour:
- Reset and clock:
  - One clock domain: clk.
  - rst is asynchronous and active-high; its assertion immediately forces reset values with no clock edge needed.
  - Reset values: state=ACCUM, acc_out=0, overflow=0, count=0, out_valid=0, in_ready=1.
- Input value: operand = {carry_in, sum_in}, zero-extended to ACC_W+1 bits.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid=1. At the clock edge: acc_out <= (acc_out + operand) mod 2^ACC_W, count <= count+1.
  - overflow is set if the (ACC_W+1)-bit sum has its MSB set.
  - If the accepted sample is number NUM_SAMPLES: count <= NUM_SAMPLES, next state = HOLD.
  - in_valid=0: no change.
- State HOLD:
  - in_ready=0, out_valid=1.
  - acc_out, overflow and count are stable; inputs are ignored even if in_valid=1.
  - When out_ready=1 at a clock edge (handshake complete): acc_out <= 0, overflow <= 0, count <= 0, next state = ACCUM.
  - A new batch's first sample can be accepted no earlier than the cycle after the handshake; there is no bypass.
- Latency: out_valid rises on the clock edge that accepts the final sample, i.e. it is visible in the cycle after that acceptance.
- Throughput: NUM_SAMPLES+1 cycles per batch minimum (NUM_SAMPLES accepts plus 1 handshake cycle).
- clear:
  - Evaluated at every clock edge; priority below rst and above all else.
  - Effect: acc_out=0, overflow=0, count=0, state=ACCUM.
  - A sample presented in the same cycle as clear is dropped. A pending HOLD total is discarded even if out_ready=1 in that cycle.
- Boundaries:
  - count never exceeds NUM_SAMPLES.
  - overflow is sticky within a batch: once set, later samples do not clear it.
  - Wrap-around is modulo 2^ACC_W.
  - Reset mid-batch discards the partial total.
- out_ready while in ACCUM has no effect.
- All outputs are registered, except in_ready and out_valid, which decode directly from the state register (no combinational path from inputs).

Optional Feature:
- Macro: SUM_ACCUMULATOR_SATURATE_EN.
- Defined: when the (ACC_W+1)-bit sum has its MSB set, acc_out <= {ACC_W{1'b1}}. acc_out then stays at all-ones for the rest of the batch, and overflow is set as before.
- Undefined: modulo wrap as described in Behaviour.
- Handshake, count and timing are identical in both builds.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle during ACCUM with count=5 -> acc_out=0, count=0, overflow=0, in_ready=1, out_valid=0 immediately, with no clock edge.
- Normal batch: 16 accepts with sum_in=4'h5, carry_in=0 -> out_valid=1 the cycle after the 16th accept, acc_out=80, overflow=0, count=16, in_ready=0.
- Wrap batch: 16 accepts with sum_in=4'hF, carry_in=1 (31 each) -> acc_out=240 (496 mod 256), overflow=1. With SUM_ACCUMULATOR_SATURATE_EN: acc_out=255, overflow=1.
- Backpressure: after batch completion, hold out_ready=0 for 10 cycles while driving in_valid=1 with sum_in=4'h3 -> acc_out stays 80 and no sample is accepted. Then pulse out_ready=1 -> next cycle out_valid=0, acc_out=0, in_ready=1.
- Gapped input: 16 samples of 2 with in_valid toggling 1/0 -> acc_out=32, and out_valid rises exactly after the 16th valid sample.
- Clear: clear=1 in HOLD together with out_ready=1 -> total is discarded, acc_out=0, state ACCUM. Separately, clear=1 with in_valid=1 in ACCUM at count=7 -> sample dropped, count=0.

Source files
------------

// File: rtl/sum_accumulator.sv
// sum_accumulator: collects NUM_SAMPLES {carry, sum} results from the
// registered 4-bit adder stage into an ACC_W-bit total. The total is then
// presented with a valid/ready handshake and held until it is taken.
// Optional build macro SUM_ACCUMULATOR_SATURATE_EN: on overflow the total
// clamps to all-ones instead of wrapping modulo 2^ACC_W.
module sum_accumulator #(
  parameter  int NUM_SAMPLES = 16,
  parameter  int ACC_W       = 8,
  localparam int CW          = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       sum_in,
  input  logic             carry_in,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   sum_ext;

  // Reduce the (ACC_W+1)-bit sum to ACC_W bits: wrap, or clamp on carry-out
  function automatic logic [ACC_W-1:0] wrap_or_sat(input logic [ACC_W:0] s);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    wrap_or_sat = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    wrap_or_sat = s[ACC_W-1:0];
`endif
  endfunction

  // Zero-extend the 5-bit adder result and form the widened running sum
  always_comb begin
    operand = {{(ACC_W - 4){1'b0}}, carry_in, sum_in};
    sum_ext = {1'b0, acc_q} + operand;
  end

  // Next-state and next-value logic; clear overrides everything but reset
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d   = wrap_or_sat(sum_ext);
            ovf_d   = ovf_q | sum_ext[ACC_W];
            count_d = count_q + CW'(1);
            if (count_q == CW'(NUM_SAMPLES - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Handshake flags decode straight from the state register
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    acc_out   = acc_q;
    overflow  = ovf_q;
    count     = count_q;
  end

endmodule
